// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage load/store unit: access size codes,
// FSM states and the bundles carried between pipeline registers.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   typedef struct packed {
      logic        is_load;
      logic [1:0]  size;
      logic        sign_ext;
      logic [31:0] addr;
      logic        dir_wb;
      logic        reg_wr;
      logic [4:0]  rd;
   } op_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   typedef struct packed {
      logic [31:0] do_data;
      logic [31:0] dir;
      logic        dir_wb;
      logic        reg_wr;
      logic [4:0]  rd;
   } wb_t;

   // Size code 2'b11 is treated as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic r;
      case (size)
         SZ_BYTE:        r = 1'b0;
         SZ_HALF:        r = lane[0];
         SZ_WORD, 2'b11: r = (lane != 2'b00);
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/acknowledge bus between the load/store unit (master) and data memory (slave).
interface mem_access_if;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic        m_ack;
   logic [31:0] m_rdata;

   modport master (
      output m_req, m_we, m_addr, m_be, m_wdata,
      input  m_ack, m_rdata
   );

   modport slave (
      input  m_req, m_we, m_addr, m_be, m_wdata,
      output m_ack, m_rdata
   );
endinterface

// File: rtl/mem_access_align.sv
// Combinational lane logic: byte enables and replicated store data for a
// request, plus little-endian alignment and extension of returned load data.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   always_comb begin
      byte_s    = rdata[{lane, 3'b000} +: 8];
      half_s    = lane[1] ? rdata[31:16] : rdata[15:0];
      be        = 4'b0000;
      wdata_rep = 32'h0000_0000;
      load_data = 32'h0000_0000;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
            load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
         end
         SZ_HALF: begin
            be        = 4'b0011 << lane;
            wdata_rep = {2{wdata[15:0]}};
            load_data = {{16{sign_ext & half_s[15]}}, half_s};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            load_data = rdata;
         end
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: runs one memory transaction per accepted load
// or store, stalls upstream meanwhile, and registers the write-back fields.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        valid_ex,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        dir_wb_in,
   input  logic        reg_wr_in,
   input  logic [4:0]  rd_in,
   mem_access_if.master mem,
   output logic [31:0] do_data,
   output logic [31:0] dir,
   output logic        dir_wb,
   output logic        reg_wr,
   output logic [4:0]  rd,
   output logic        valid_wb,
   output logic        stall,
   output logic        misalign,
   output logic        err
);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_t              op_q, op_d;
   bus_t             bus_q, bus_d;
   wb_t              wb_q, wb_d;
   logic             valid_wb_q, valid_wb_d;
   logic             stall_q, stall_d;
   logic             misalign_q, misalign_d;
   logic             err_q, err_d;

   logic [1:0]  al_size;
   logic        al_sign;
   logic [1:0]  al_lane;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_load;

   // In IDLE the aligner sees the incoming operation; in ACCESS the captured one.
   assign al_size = (state_q == IDLE) ? size        : op_q.size;
   assign al_sign = (state_q == IDLE) ? sign_ext    : op_q.sign_ext;
   assign al_lane = (state_q == IDLE) ? addr[1:0]   : op_q.addr[1:0];

   mem_align u_align (
      .size      (al_size),
      .sign_ext  (al_sign),
      .lane      (al_lane),
      .wdata     (wdata),
      .rdata     (mem.m_rdata),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .load_data (al_load)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      bus_d      = bus_q;
      wb_d       = wb_q;
      valid_wb_d = 1'b0;
      stall_d    = stall_q;
      misalign_d = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_ex && !mem_rd && !mem_wr) begin
               wb_d       = '{do_data: 32'h0, dir: addr, dir_wb: dir_wb_in, reg_wr: reg_wr_in, rd: rd_in};
               valid_wb_d = 1'b1;
            end else if (valid_ex && is_misaligned(size, addr[1:0])) begin
               wb_d       = '{do_data: 32'h0, dir: addr, dir_wb: dir_wb_in, reg_wr: 1'b0, rd: rd_in};
               valid_wb_d = 1'b1;
               misalign_d = 1'b1;
            end else if (valid_ex) begin
               op_d    = '{is_load: mem_rd, size: size, sign_ext: sign_ext, addr: addr,
                           dir_wb: dir_wb_in, reg_wr: reg_wr_in, rd: rd_in};
               bus_d   = '{req: 1'b1, we: mem_wr, addr: {addr[31:2], 2'b00}, be: al_be, wdata: al_wdata};
               cnt_d   = {CNT_W{1'b0}};
               stall_d = 1'b1;
               state_d = ACCESS;
            end else begin
               valid_wb_d = 1'b0;
            end
         end
         ACCESS: begin
            // An ack on the final counted cycle still completes the access.
            if (mem.m_ack) begin
               wb_d       = '{do_data: op_q.is_load ? al_load : 32'h0, dir: op_q.addr,
                              dir_wb: op_q.dir_wb, reg_wr: op_q.reg_wr, rd: op_q.rd};
               valid_wb_d = 1'b1;
               bus_d      = '0;
               stall_d    = 1'b0;
               state_d    = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               wb_d       = '{do_data: 32'h0, dir: op_q.addr, dir_wb: op_q.dir_wb, reg_wr: 1'b0, rd: op_q.rd};
               valid_wb_d = 1'b1;
               err_d      = 1'b1;
               bus_d      = '0;
               stall_d    = 1'b0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            bus_d   = '0;
            stall_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         op_q       <= '0;
         bus_q      <= '0;
         wb_q       <= '0;
         valid_wb_q <= 1'b0;
         stall_q    <= 1'b0;
         misalign_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         bus_q      <= bus_d;
         wb_q       <= wb_d;
         valid_wb_q <= valid_wb_d;
         stall_q    <= stall_d;
         misalign_q <= misalign_d;
         err_q      <= err_d;
      end
   end

   assign mem.m_req   = bus_q.req;
   assign mem.m_we    = bus_q.we;
   assign mem.m_addr  = bus_q.addr;
   assign mem.m_be    = bus_q.be;
   assign mem.m_wdata = bus_q.wdata;
   assign do_data     = wb_q.do_data;
   assign dir         = wb_q.dir;
   assign dir_wb      = wb_q.dir_wb;
   assign reg_wr      = wb_q.reg_wr;
   assign rd          = wb_q.rd;
   assign valid_wb    = valid_wb_q;
   assign stall       = stall_q;
   assign misalign    = misalign_q;
   assign err         = err_q;
endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a transaction-level
// reference model that derives lanes and load values arithmetically.
module tb_mem_access;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, valid_ex, mem_rd, mem_wr, sign_ext, dir_wb_in, reg_wr_in;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_in;
   logic [31:0] do_data, dir;
   logic        dir_wb, reg_wr, valid_wb, stall, misalign, err;
   logic [4:0]  rd;

   mem_access_if bus();

   mem_access #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .valid_ex(valid_ex), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .dir_wb_in(dir_wb_in),
      .reg_wr_in(reg_wr_in), .rd_in(rd_in), .mem(bus), .do_data(do_data), .dir(dir),
      .dir_wb(dir_wb), .reg_wr(reg_wr), .rd(rd), .valid_wb(valid_wb), .stall(stall),
      .misalign(misalign), .err(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_m_req"}, bus.m_req, 1'b0);    chk({tag, "_m_we"}, bus.m_we, 1'b0);
      chk({tag, "_m_addr"}, bus.m_addr, 32'h0); chk({tag, "_m_be"}, bus.m_be, 4'h0);
      chk({tag, "_m_wdata"}, bus.m_wdata, 32'h0);
      chk({tag, "_do"}, do_data, 32'h0);        chk({tag, "_dir"}, dir, 32'h0);
      chk({tag, "_dir_wb"}, dir_wb, 1'b0);      chk({tag, "_reg_wr"}, reg_wr, 1'b0);
      chk({tag, "_rd"}, rd, 5'd0);              chk({tag, "_valid_wb"}, valid_wb, 1'b0);
      chk({tag, "_stall"}, stall, 1'b0);        chk({tag, "_misalign"}, misalign, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
   endtask

   task automatic idle_cycle(input logic ack);
      valid_ex    = 1'b0;
      bus.m_ack   = ack;
      bus.m_rdata = $urandom;
      @(posedge clk); #1;
      bus.m_ack = 1'b0;
      chk("idle_valid_wb", valid_wb, 1'b0);
      chk("idle_misalign", misalign, 1'b0);
      chk("idle_err", err, 1'b0);
      chk("idle_m_req", bus.m_req, 1'b0);
      chk("idle_stall", stall, 1'b0);
   endtask

   // Issue one operation from IDLE; k is the cycle (1-based, counted from the
   // first M_REQ cycle) on which the memory acknowledges.
   task automatic run_op(input logic op_rd, input logic op_wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input logic dwb, input logic rwr, input logic [4:0] rdi, input int k);
      int          nb, off;
      logic [3:0]  ebe;
      logic [31:0] ewd, edo, mask;
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      off = int'(a[1:0]);
      ebe = 4'h0;
      ewd = 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (b >= off && b < off + nb) ebe[b] = 1'b1;
         ewd[8*b +: 8] = wd[8*(b % nb) +: 8];
      end
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      edo  = (rdat >> (8 * off)) & mask;
      if (sg && edo[8*nb-1]) edo = edo | ~mask;
      if (!op_rd) edo = 32'h0;

      valid_ex = 1'b1; mem_rd = op_rd; mem_wr = op_wr; size = sz; sign_ext = sg;
      addr = a; wdata = wd; dir_wb_in = dwb; reg_wr_in = rwr; rd_in = rdi;
      @(posedge clk); #1;
      valid_ex = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = $urandom; wdata = $urandom;

      if (!op_rd && !op_wr) begin
         chk("pt_valid_wb", valid_wb, 1'b1); chk("pt_dir", dir, a);     chk("pt_do", do_data, 32'h0);
         chk("pt_dir_wb", dir_wb, dwb);      chk("pt_reg_wr", reg_wr, rwr); chk("pt_rd", rd, rdi);
         chk("pt_stall", stall, 1'b0);       chk("pt_m_req", bus.m_req, 1'b0);
      end else if (off % nb != 0) begin
         chk("mis_valid_wb", valid_wb, 1'b1); chk("mis_pulse", misalign, 1'b1);
         chk("mis_reg_wr", reg_wr, 1'b0);     chk("mis_m_req", bus.m_req, 1'b0);
         chk("mis_stall", stall, 1'b0);       chk("mis_err", err, 1'b0);
      end else begin
         chk("acc_valid_wb0", valid_wb, 1'b0);
         for (int j = 1; j <= int'(TO); j++) begin
            chk("acc_m_req", bus.m_req, 1'b1);   chk("acc_stall", stall, 1'b1);
            chk("acc_m_we", bus.m_we, op_wr);     chk("acc_m_addr", bus.m_addr, {a[31:2], 2'b00});
            chk("acc_m_be", bus.m_be, ebe);       chk("acc_m_wdata", bus.m_wdata, ewd);
            bus.m_ack   = (j == k);
            bus.m_rdata = (j == k) ? rdat : $urandom;
            @(posedge clk); #1;
            bus.m_ack = 1'b0;
            if (j == k) begin
               chk("ack_valid_wb", valid_wb, 1'b1); chk("ack_err", err, 1'b0);
               chk("ack_do", do_data, edo);         chk("ack_dir", dir, a);
               chk("ack_reg_wr", reg_wr, rwr);      chk("ack_rd", rd, rdi);
               chk("ack_dir_wb", dir_wb, dwb);      chk("ack_m_req", bus.m_req, 1'b0);
               chk("ack_stall", stall, 1'b0);
               break;
            end else if (j == int'(TO)) begin
               chk("to_valid_wb", valid_wb, 1'b1); chk("to_err", err, 1'b1);
               chk("to_reg_wr", reg_wr, 1'b0);     chk("to_m_req", bus.m_req, 1'b0);
               chk("to_stall", stall, 1'b0);
            end else begin
               chk("acc_valid_wb", valid_wb, 1'b0);
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; valid_ex = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
      addr = 32'h0; wdata = 32'h0; dir_wb_in = 1'b0; reg_wr_in = 1'b0; rd_in = 5'd0;
      bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      reset_n = 1'b1;

      run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 1'b1, 5'd5, 1);
      chk("plan_pt_dir", dir, 32'h0000_1234);
      idle_cycle(1'b0);
      run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1'b0, 1'b1, 5'd7, 3);
      chk("plan_sbl_do", do_data, 32'hFFFF_FF80);
      run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 2);
      chk("plan_hs_do", do_data, 32'h0);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b0, 1'b1, 5'd3, 1);
      idle_cycle(1'b0);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b1, 5'd9, 99);
      idle_cycle(1'b1);
      idle_cycle(1'b0);
      run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0082, 32'h0, 32'hC001_0000, 1'b0, 1'b1, 5'd4, int'(TO));

      valid_ex = 1'b1; mem_rd = 1'b1; size = 2'b10; addr = 32'h0000_0080;
      @(posedge clk); #1;
      valid_ex = 1'b0; mem_rd = 1'b0;
      chk("rst_pre_m_req", bus.m_req, 1'b1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk_zero("rst_mid");
      reset_n = 1'b1;
      idle_cycle(1'b0);
      run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0091, 32'h0, 32'hAABB_CCDD, 1'b1, 1'b1, 5'd11, 1);

      for (int n = 0; n < 200; n++) begin
         int          kind;
         logic [31:0] ra;
         kind = $urandom_range(0, 2);
         ra   = $urandom;
         if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
         run_op(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra,
                $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom_range(1, 6));
      end
      idle_cycle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage load/store unit of the pipelined datapath. Takes the EX/MEM stage operation, runs a request/acknowledge transaction with data memory for loads and stores, aligns and extends load data, and registers DO, DIR and DIR_WB for the write-back select stage. Non-memory operations pass through with one cycle of latency. Memory operations stall the pipeline until the memory acknowledges or a timeout occurs.

## Interface
- TIMEOUT, 255: maximum cycles in ACCESS waiting for M_ACK before the access is aborted. Must be at least 1.
- CLK  in  1  clock. All logic is rising-edge.
- RESET_N  in  1  synchronous, active-low reset.
- VALID_EX  in  1  EX/MEM holds a valid operation.
- MEM_RD, MEM_WR  in  1 each  load / store. At most one is set.
- SIZE  in  2  access size: 00 byte, 01 half, 10 word. 11 is treated as word.
- SIGNED  in  1  sign-extend loads. 0 means zero-extend.
- ADDR  in  32  ALU result. This is the byte address for memory operations and the pass-through value otherwise.
- WDATA  in  32  store data, right-justified.
- DIR_WB_IN, REG_WR_IN  in  1 each  write-back select and register-write enable, passed through.
- RD_IN  in  5  destination register.
- M_REQ  out  1  memory request.
- M_WE  out  1  write enable.
- M_ADDR  out  32  word-aligned address, {ADDR[31:2],2'b00}.
- M_BE  out  4  byte enables.
- M_WDATA  out  32  lane-replicated store data.
- M_ACK  in  1  memory completion.
- M_RDATA  in  32  read word, valid with M_ACK.
- DO, DIR  out  32 each  load result and ALU result, to write-back.
- DIR_WB, REG_WR  out  1 each  to write-back.
- RD  out  5  to write-back.
- VALID_WB  out  1  write-back registers are valid this cycle.
- STALL  out  1  upstream must hold its inputs.
- MISALIGN, ERR  out  1 each  single-cycle fault pulses.

## Operation
States:
- **IDLE**
  - If VALID_EX and neither MEM_RD nor MEM_WR is set: load the write-back registers from the inputs, set DO=0 and VALID_WB=1.
  - If VALID_EX and a memory operation is misaligned (half with ADDR[0]=1, or word with ADDR[1:0]≠0): issue no request, pulse MISALIGN, set VALID_WB=1 with REG_WR=0.
  - Any other VALID_EX memory operation: capture the operation, go to ACCESS, set VALID_WB=0.
  - No VALID_EX: VALID_WB=0.
- **ACCESS**
  - M_REQ=1, with M_WE/M_ADDR/M_BE/M_WDATA held from the captured operation. STALL=1.
  - When M_ACK is sampled high: load the write-back registers and set VALID_WB=1. For a load, DO is the aligned read data. For a store, DO=0. Return to IDLE.
  - When the cycle counter reaches TIMEOUT without M_ACK: drop M_REQ, pulse ERR, set VALID_WB=1 with REG_WR=0, return to IDLE.
- While in ACCESS, inputs are ignored.

Byte enables and store data:
- Byte: M_BE=0001<<ADDR[1:0], M_WDATA={4{WDATA[7:0]}}.
- Half: M_BE=0011<<ADDR[1:0], M_WDATA={2{WDATA[15:0]}}.
- Word: M_BE=1111, M_WDATA=WDATA.

Load alignment:
- Little-endian.
- Byte lane selected by ADDR[1:0], half selected by ADDR[1].
- Extended to 32 bits according to SIGNED.

## Timing
- Reset: state IDLE, counter 0. Every output is 0: M_REQ, M_WE, M_ADDR, M_BE, M_WDATA, DO, DIR, DIR_WB, REG_WR, RD, VALID_WB, STALL, MISALIGN, ERR.
- Reset asserted during ACCESS aborts the access. M_REQ is 0 after that edge. No ERR, no VALID_WB.
- Non-memory or misaligned operation: outputs are registered, 1-cycle latency.
- Memory operation accepted at edge N:
  - M_REQ and STALL are high from N+1.
  - If M_ACK is seen at edge N+k: VALID_WB is high in cycle N+k+1, M_REQ is low from N+k+1, and the next operation is accepted at edge N+k+1. This leaves one bubble.
- M_ACK in the same cycle that M_REQ first rises is legal, giving k=1.
- M_ACK while in IDLE is ignored.
- MISALIGN, ERR and VALID_WB are high for exactly one cycle per event.
- If M_ACK arrives on the same edge the counter reaches TIMEOUT, the ACK wins and ERR is not pulsed.

## Structure
- Shared package holds the SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum (IDLE, ACCESS).
- Sub-module mem_align is purely combinational. It takes SIZE, SIGNED, ADDR[1:0], WDATA and M_RDATA, and produces M_BE, M_WDATA and the aligned load data.
- The top level contains the FSM, the timeout counter and the write-back registers.

## Test plan
- **Pass-through:** VALID_EX=1, ADDR=0x00001234, DIR_WB_IN=1, RD_IN=5, REG_WR_IN=1. Next cycle: DIR=0x00001234, DIR_WB=1, RD=5, VALID_WB=1, STALL=0.
- **Signed byte load:** ADDR=0x103, SIGNED=1. M_ACK arrives 3 cycles after M_REQ rises, with M_RDATA=0x80FF7F01. M_ADDR=0x100, M_BE=1000. After the ack: DO=0xFFFFFF80, VALID_WB=1. STALL is high for exactly 3 cycles.
- **Half store:** ADDR=0x22, WDATA=0x0000BEEF. M_WE=1, M_BE=1100, M_WDATA=0xBEEFBEEF. After the ack: DO=0, VALID_WB=1.
- **Misaligned word load:** ADDR=0x6. M_REQ stays 0. MISALIGN pulses once. VALID_WB=1 with REG_WR=0.
- **Timeout:** TIMEOUT=4 and M_ACK never arrives. M_REQ is high for 4 cycles, then ERR pulses and the FSM returns to IDLE. A late M_ACK afterwards is ignored.
- **Reset mid-access:** RESET_N=0 while in ACCESS. After that edge: M_REQ=0, STALL=0, all outputs 0. A new operation is accepted normally once reset is released.
